// File: rtl/pwm_actuator.sv
// Complementary PWM actuator: takes a signed fixed-point control word over valid/ready,
// saturates it to a duty count and applies it at period boundaries with dead time.
module pwm_actuator #(
   parameter int PERIOD    = 1000,
   parameter int CNT_W     = 11,
   parameter int FRAC_BITS = 16,
   parameter int DEADTIME  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [31:0]      ctrl_in,
   input  logic             ctrl_valid,
   output logic             ctrl_ready,
   output logic             pwm_h,
   output logic             pwm_l,
   output logic             period_start,
   output logic [CNT_W-1:0] duty_out,
   output logic             sat_hi,
   output logic             sat_lo
);

   typedef struct packed {
      logic [CNT_W-1:0] duty;
      logic             hi;
      logic             lo;
   } sample_t;

   localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] PER    = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] DT     = CNT_W'(DEADTIME);
   localparam logic [CNT_W:0]   DT_EXT = (CNT_W+1)'(DEADTIME);

   logic [CNT_W-1:0]   cnt;
   sample_t            applied_q, pend_q, conv;
   logic               pend_full;
   logic signed [31:0] shifted;
   logic               accept, tick, apply_now, bypass;
   logic [CNT_W:0]     l_start;

   always_comb begin
      conv    = '0;
      shifted = $signed(ctrl_in) >>> FRAC_BITS;
      if (shifted < 0) begin
         conv.lo = 1'b1;
      end else if (shifted > PERIOD) begin
         conv.duty = PER;
         conv.hi   = 1'b1;
      end else begin
         conv.duty = shifted[CNT_W-1:0];
      end
   end

   assign ctrl_ready = !pend_full && !rst;
   assign accept     = ctrl_valid && ctrl_ready;
   assign tick       = enable && (cnt == LAST);
   // While disabled there is no period boundary to wait for, so pending drains at once.
   assign apply_now  = pend_full && (tick || !enable);
   assign bypass     = accept && tick;
   // Extra bit so duty near PERIOD plus dead time cannot wrap and re-enable the low side.
   assign l_start    = {1'b0, applied_q.duty} + DT_EXT;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         applied_q    <= '0;
         pend_q       <= '0;
         pend_full    <= 1'b0;
         pwm_h        <= 1'b0;
         pwm_l        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         if (!enable)     cnt <= '0;
         else if (tick)   cnt <= '0;
         else             cnt <= cnt + 1'b1;

         if (apply_now) begin
            applied_q <= pend_q;
            pend_full <= 1'b0;
         end else if (bypass) begin
            applied_q <= conv;
         end else if (accept) begin
            pend_q    <= conv;
            pend_full <= 1'b1;
         end

         pwm_h        <= enable && (cnt >= DT) && (cnt < applied_q.duty);
         pwm_l        <= enable && ({1'b0, cnt} >= l_start) && (cnt < PER);
         period_start <= enable && (cnt == '0);
      end
   end

   assign duty_out = applied_q.duty;
   assign sat_hi   = applied_q.hi;
   assign sat_lo   = applied_q.lo;

endmodule

// File: tb/tb_pwm_actuator.sv
// Directed table-driven bench for pwm_actuator (PERIOD=10, DEADTIME=1) plus a random overlap soak.
module tb_pwm_actuator;

   logic        clk = 1'b0;
   logic        rst, enable, ctrl_valid;
   logic [31:0] ctrl_in;
   logic        ctrl_ready, pwm_h, pwm_l, period_start, sat_hi, sat_lo;
   logic [3:0]  duty_out;

   int checks = 0;
   int failures = 0;

   pwm_actuator #(.PERIOD(10), .CNT_W(4), .FRAC_BITS(16), .DEADTIME(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
      .ctrl_ready(ctrl_ready), .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start),
      .duty_out(duty_out), .sat_hi(sat_hi), .sat_lo(sat_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, vld;
      logic [31:0] din;
      logic        rdy, h, l, ps;
      logic [3:0]  duty;
      logic        hi, lo;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
      end
   endtask

   // d is the integer part of the control word; expected outputs are those seen just after the edge.
   task automatic v(input bit en, input bit vld, input int d, input bit rdy, input bit h,
                    input bit l, input bit ps, input int duty, input bit hi, input bit lo);
      vec_t r;
      r.en = en; r.vld = vld; r.din = d <<< 16;
      r.rdy = rdy; r.h = h; r.l = l; r.ps = ps; r.duty = 4'(duty); r.hi = hi; r.lo = lo;
      vecs.push_back(r);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input int idx, input logic rdy, input logic h,
                           input logic l, input logic ps, input logic [3:0] duty,
                           input logic hi, input logic lo);
      chk({tag, ".ready"}, idx, 32'(ctrl_ready), 32'(rdy));
      chk({tag, ".pwm_h"}, idx, 32'(pwm_h), 32'(h));
      chk({tag, ".pwm_l"}, idx, 32'(pwm_l), 32'(l));
      chk({tag, ".pstart"}, idx, 32'(period_start), 32'(ps));
      chk({tag, ".duty"}, idx, 32'(duty_out), 32'(duty));
      chk({tag, ".sat_hi"}, idx, 32'(sat_hi), 32'(hi));
      chk({tag, ".sat_lo"}, idx, 32'(sat_lo), 32'(lo));
   endtask

   initial begin
      logic ph, pl;

      // Period A: duty 0, accept 5.0 at cnt 3, applied at cnt 9.
      v(1,0,0, 1,0,0,1,0,0,0);
      v(1,0,0, 1,0,1,0,0,0,0);
      v(1,0,0, 1,0,1,0,0,0,0);
      v(1,1,5, 0,0,1,0,0,0,0);
      for (int i = 0; i < 5; i++) v(1,0,0, 0,0,1,0,0,0,0);
      v(1,0,0, 1,0,1,0,5,0,0);
      // Period B: duty 5 (h cnt 1..4, l cnt 6..9), accept -3.0 at cnt 2.
      v(1,0,0, 1,0,0,1,5,0,0);
      v(1,0,0, 1,1,0,0,5,0,0);
      v(1,1,-3, 0,1,0,0,5,0,0);
      v(1,0,0, 0,1,0,0,5,0,0);
      v(1,0,0, 0,1,0,0,5,0,0);
      v(1,0,0, 0,0,0,0,5,0,0);
      for (int i = 0; i < 3; i++) v(1,0,0, 0,0,1,0,5,0,0);
      v(1,0,0, 1,0,1,0,0,0,1);
      // Period C: duty 0 with sat_lo, accept 20.0 at cnt 5.
      v(1,0,0, 1,0,0,1,0,0,1);
      for (int i = 0; i < 4; i++) v(1,0,0, 1,0,1,0,0,0,1);
      v(1,1,20, 0,0,1,0,0,0,1);
      for (int i = 0; i < 3; i++) v(1,0,0, 0,0,1,0,0,0,1);
      v(1,0,0, 1,0,1,0,10,1,0);
      // Period D: duty 10 with sat_hi; accept 2.0 at cnt 2, then 7.0 held valid.
      v(1,0,0, 1,0,0,1,10,1,0);
      v(1,0,0, 1,1,0,0,10,1,0);
      v(1,1,2, 0,1,0,0,10,1,0);
      for (int i = 0; i < 6; i++) v(1,1,7, 0,1,0,0,10,1,0);
      v(1,1,7, 1,1,0,0,2,0,0);
      // Period E: duty 2; 7.0 lands in pending at cnt 0 once it frees up.
      v(1,1,7, 0,0,0,1,2,0,0);
      v(1,0,0, 0,1,0,0,2,0,0);
      v(1,0,0, 0,0,0,0,2,0,0);
      for (int i = 0; i < 6; i++) v(1,0,0, 0,0,1,0,2,0,0);
      v(1,0,0, 1,0,1,0,7,0,0);
      // Period F: duty 7; accept 5.0 at cnt 9 with pending empty goes straight to duty.
      v(1,0,0, 1,0,0,1,7,0,0);
      for (int i = 0; i < 6; i++) v(1,0,0, 1,1,0,0,7,0,0);
      v(1,0,0, 1,0,0,0,7,0,0);
      v(1,0,0, 1,0,1,0,7,0,0);
      v(1,1,5, 1,0,1,0,5,0,0);
      // Period G: duty 5, enable dropped at cnt 6; sample accepted while disabled applies next cycle.
      v(1,0,0, 1,0,0,1,5,0,0);
      for (int i = 0; i < 4; i++) v(1,0,0, 1,1,0,0,5,0,0);
      v(1,0,0, 1,0,0,0,5,0,0);
      v(0,0,0, 1,0,0,0,5,0,0);
      v(0,1,8, 0,0,0,0,5,0,0);
      v(0,0,0, 1,0,0,0,8,0,0);
      v(1,0,0, 1,0,0,1,8,0,0);
      v(1,0,0, 1,1,0,0,8,0,0);
      v(1,0,0, 1,1,0,0,8,0,0);

      // Reset held 3 cycles with a valid sample presented.
      rst = 1'b1; enable = 1'b1; ctrl_valid = 1'b1; ctrl_in = 32'h0005_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_outs("reset", i, 0, 0, 0, 0, 4'd0, 0, 0);
      end
      rst = 1'b0; ctrl_valid = 1'b0; ctrl_in = '0;
      #1;
      chk("release.ready", 0, 32'(ctrl_ready), 32'd1);

      foreach (vecs[i]) begin
         enable = vecs[i].en; ctrl_valid = vecs[i].vld; ctrl_in = vecs[i].din;
         step();
         chk_outs("vec", i, vecs[i].rdy, vecs[i].h, vecs[i].l, vecs[i].ps,
                  vecs[i].duty, vecs[i].hi, vecs[i].lo);
      end

      // Reset mid-period (cnt 4) with 4.0 pending: sample must not survive.
      enable = 1'b1; ctrl_valid = 1'b1; ctrl_in = 32'h0004_0000;
      step();
      chk("rstmid.pend_ready", 0, 32'(ctrl_ready), 32'd0);
      chk("rstmid.pend_duty", 0, 32'(duty_out), 32'd8);
      rst = 1'b1; ctrl_valid = 1'b0; ctrl_in = '0;
      step();
      chk_outs("rstmid", 1, 0, 0, 0, 0, 4'd0, 0, 0);
      rst = 1'b0;
      #1;
      chk("rstmid.ready", 2, 32'(ctrl_ready), 32'd1);
      for (int i = 0; i < 12; i++) step();
      chk("rstmid.duty_after", 3, 32'(duty_out), 32'd0);
      chk("rstmid.ready_after", 3, 32'(ctrl_ready), 32'd1);

      // Random soak: outputs never overlap and never switch side without a gap.
      ph = pwm_h; pl = pwm_l;
      for (int i = 0; i < 10000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         enable     = ($urandom_range(0, 49) != 0);
         ctrl_valid = ($urandom_range(0, 3) == 0);
         ctrl_in    = {16'($signed($urandom_range(0, 23)) - 16'sd6), 16'($urandom)};
         step();
         chk("rand.overlap", i, 32'(pwm_h & pwm_l), 32'd0);
         chk("rand.deadgap", i, 32'((ph & pwm_l) | (pl & pwm_h)), 32'd0);
         ph = pwm_h; pl = pwm_l;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
